prog_run_ctrl: RTL and testbench

Run controller that sequences one program execution on the 9-bit single-cycle core. It accepts a host Start and a program select, then drives the core's PC-reset/start strobe and start address. It gates the core with a run enable, counts executed cycles and watches the core's halt flag. It reports completion (halted, timed out or aborted) to the host through Ack and a status code, sitting between the test harness and the core's fetch/halt logic.

---
 rtl/prog_run_ctrl.sv | 118 +++++++++++
 tb/tb_prog_run_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_run_ctrl.sv
// Run controller for the 9-bit single-cycle core: launches one program from a
// selected base address, gates the core while it runs, and reports how the run ended.
module prog_run_ctrl #(
    parameter int              PCW     = 10,
    parameter int              CTW     = 16,
    parameter logic [CTW-1:0]  TIMEOUT = 16'd4000,
    parameter logic [PCW-1:0]  BASE0   = 10'd0,
    parameter logic [PCW-1:0]  BASE1   = 10'd128,
    parameter logic [PCW-1:0]  BASE2   = 10'd256,
    parameter logic [PCW-1:0]  BASE3   = 10'd384
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       ProgSel,
    input  logic             Abort,
    input  logic             CoreHalt,
    output logic             CoreStart,
    output logic [PCW-1:0]   ProgBase,
    output logic             CoreRun,
    output logic             Busy,
    output logic             Ack,
    output logic [1:0]       Status,
    output logic [CTW-1:0]   CycleCt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HALTED  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORTED = 2'b11;

    state_t           state_q, state_d;
    logic [PCW-1:0]   prog_base_q, prog_base_d;
    logic [1:0]       status_q, status_d;
    logic [CTW-1:0]   cycle_ct_q, cycle_ct_d;
    logic [PCW-1:0]   base_sel;

    always_comb begin
        case (ProgSel)
            2'd0:    base_sel = BASE0;
            2'd1:    base_sel = BASE1;
            2'd2:    base_sel = BASE2;
            default: base_sel = BASE3;
        endcase
    end

    // NOTE: every variable gets a hold default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d     = state_q;
        prog_base_d = prog_base_q;
        status_d    = status_q;
        cycle_ct_d  = cycle_ct_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d     = S_LAUNCH;
                    prog_base_d = base_sel;
                    status_d    = ST_NONE;
                    cycle_ct_d  = '0;
                end
            end
            S_LAUNCH: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // Halt outranks abort, abort outranks timeout; none of them count a cycle.
                if (CoreHalt) begin
                    state_d  = S_DONE;
                    status_d = ST_HALTED;
                end else if (Abort) begin
                    state_d  = S_DONE;
                    status_d = ST_ABORTED;
                end else if (cycle_ct_q == TIMEOUT) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end else begin
                    cycle_ct_d = cycle_ct_q + CTW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update
    // together from values sampled before the edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            prog_base_q <= BASE0;
            status_q    <= ST_NONE;
            cycle_ct_q  <= '0;
        end else begin
            state_q     <= state_d;
            prog_base_q <= prog_base_d;
            status_q    <= status_d;
            cycle_ct_q  <= cycle_ct_d;
        end
    end

    // All outputs decode registers only, so reset clears them without a clock.
    assign CoreStart = (state_q == S_LAUNCH);
    assign CoreRun   = (state_q == S_RUN);
    assign Busy      = (state_q == S_LAUNCH) || (state_q == S_RUN);
    assign Ack       = (state_q == S_DONE);
    assign Status    = status_q;
    assign CycleCt   = cycle_ct_q;
    assign ProgBase  = prog_base_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Randomized bench for prog_run_ctrl: each run's outcome is predicted from the
// first RUN cycle at which halt, abort or the timeout bound takes effect.
module tb_prog_run_ctrl;

    localparam int PCW = 10;
    localparam int CTW = 16;
    localparam int TO  = 8;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start;
    logic [1:0]       ProgSel;
    logic             Abort;
    logic             CoreHalt;
    logic             CoreStart;
    logic [PCW-1:0]   ProgBase;
    logic             CoreRun;
    logic             Busy;
    logic             Ack;
    logic [1:0]       Status;
    logic [CTW-1:0]   CycleCt;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]       last_status;
    logic [CTW-1:0]   last_ct;
    logic [PCW-1:0]   last_base;

    prog_run_ctrl #(
        .PCW     (PCW),
        .CTW     (CTW),
        .TIMEOUT (16'(TO))
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .ProgSel   (ProgSel),
        .Abort     (Abort),
        .CoreHalt  (CoreHalt),
        .CoreStart (CoreStart),
        .ProgBase  (ProgBase),
        .CoreRun   (CoreRun),
        .Busy      (Busy),
        .Ack       (Ack),
        .Status    (Status),
        .CycleCt   (CycleCt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [PCW-1:0] base_of(input logic [1:0] s);
        return PCW'(128 * int'(s));
    endfunction

    // Launch one run; h / a are the 1-based RUN cycles where CoreHalt rises / Abort
    // pulses (0 = never). hold keeps Start high throughout.
    task automatic run_prog(input logic [1:0] sel, input int h, input int a, input bit hold);
        int             n;
        logic [1:0]     exp_st;
        logic [PCW-1:0] exp_base;
        bit             done;
        exp_base = base_of(sel);
        n = TO + 1;
        if (a > 0 && a < n) n = a;
        if (h > 0 && h <= n) n = h;
        exp_st = (h == n) ? 2'b01 : (a == n) ? 2'b11 : 2'b10;

        Start = 1'b1; ProgSel = sel;
        step();
        check("launch_corestart", 32'(CoreStart), 32'd1);
        check("launch_busy",      32'(Busy),      32'd1);
        check("launch_ack",       32'(Ack),       32'd0);
        check("launch_corerun",   32'(CoreRun),   32'd0);
        check("launch_base",      32'(ProgBase),  32'(exp_base));
        check("launch_status",    32'(Status),    32'd0);
        check("launch_ct",        32'(CycleCt),   32'd0);

        Start    = hold ? 1'b1 : 1'($urandom_range(0, 1));
        ProgSel  = 2'($urandom);
        Abort    = 1'($urandom);
        CoreHalt = 1'($urandom);
        step();
        check("entry_corerun",   32'(CoreRun),   32'd1);
        check("entry_corestart", 32'(CoreStart), 32'd0);
        check("entry_ct",        32'(CycleCt),   32'd0);

        done = 1'b0;
        for (int c = 1; c <= TO + 1 && !done; c++) begin
            Start    = hold ? 1'b1 : 1'($urandom_range(0, 1));
            ProgSel  = 2'($urandom);
            CoreHalt = (h > 0 && c >= h);
            Abort    = (c == a);
            step();
            if (c == n) begin
                done = 1'b1;
            end else begin
                check("run_corerun",   32'(CoreRun),   32'd1);
                check("run_corestart", 32'(CoreStart), 32'd0);
                check("run_ack",       32'(Ack),       32'd0);
                check("run_ct",        32'(CycleCt),   32'(c));
                check("run_base",      32'(ProgBase),  32'(exp_base));
            end
        end

        check("done_ack",     32'(Ack),      32'd1);
        check("done_corerun", 32'(CoreRun),  32'd0);
        check("done_busy",    32'(Busy),     32'd0);
        check("done_status",  32'(Status),   32'(exp_st));
        check("done_ct",      32'(CycleCt),  32'(n - 1));
        check("done_base",    32'(ProgBase), 32'(exp_base));
        last_status = exp_st;
        last_ct     = CTW'(n - 1);
        last_base   = exp_base;
        Abort = 1'b0; CoreHalt = 1'b0;
        if (!hold) Start = 1'b0;
    endtask

    task automatic dwell_done(input int k);
        for (int i = 0; i < k; i++) begin
            Start = 1'b0; Abort = 1'($urandom); CoreHalt = 1'($urandom); ProgSel = 2'($urandom);
            step();
            check("dwell_ack",    32'(Ack),      32'd1);
            check("dwell_status", 32'(Status),   32'(last_status));
            check("dwell_ct",     32'(CycleCt),  32'(last_ct));
            check("dwell_base",   32'(ProgBase), 32'(last_base));
        end
        Abort = 1'b0; CoreHalt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; ProgSel = 2'd0; Abort = 1'b0; CoreHalt = 1'b0;
        #12;
        check("rst_busy",   32'(Busy),      32'd0);
        check("rst_ack",    32'(Ack),       32'd0);
        check("rst_start",  32'(CoreStart), 32'd0);
        check("rst_status", 32'(Status),    32'd0);
        check("rst_ct",     32'(CycleCt),   32'd0);
        check("rst_base",   32'(ProgBase),  32'd0);
        Reset = 1'b0;
        step();

        // Abort while idle does nothing.
        Abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_abort_busy",   32'(Busy),   32'd0);
            check("idle_abort_ack",    32'(Ack),    32'd0);
            check("idle_abort_status", 32'(Status), 32'd0);
        end
        Abort = 1'b0;

        run_prog(2'd2, 6, 0, 1'b0);   // normal: halt in 6th RUN cycle
        dwell_done(2);
        run_prog(2'd0, 0, 0, 1'b0);   // timeout
        dwell_done(1);
        run_prog(2'd3, 4, 4, 1'b0);   // halt beats abort
        run_prog(2'd1, 0, 3, 1'b0);   // abort at 3rd RUN cycle
        run_prog(2'd2, 1, 0, 1'b0);   // minimum run
        run_prog(2'd1, TO + 1, TO + 1, 1'b0); // halt wins on the timeout cycle

        // Asynchronous reset in the middle of a run.
        Start = 1'b1; ProgSel = 2'd2;
        step();
        Start = 1'b0;
        step();
        for (int i = 0; i < 3; i++) step();
        check("prereset_ct", 32'(CycleCt), 32'd3);
        #3 Reset = 1'b1;
        #1;
        check("midrst_busy",    32'(Busy),     32'd0);
        check("midrst_corerun", 32'(CoreRun),  32'd0);
        check("midrst_ct",      32'(CycleCt),  32'd0);
        check("midrst_base",    32'(ProgBase), 32'd0);
        #2 Reset = 1'b0;
        step();
        check("postrst_busy", 32'(Busy), 32'd0);
        run_prog(2'd1, 3, 0, 1'b0);

        // Back-to-back with Start held: halt then timeout.
        run_prog(2'd3, 2, 0, 1'b1);
        run_prog(2'd0, 0, 0, 1'b1);
        Start = 1'b0;
        dwell_done(1);

        for (int r = 0; r < 25; r++) begin
            bit hold;
            hold = 1'($urandom);
            run_prog(2'($urandom), $urandom_range(0, TO + 3), $urandom_range(0, TO + 3), hold);
            if (!hold) dwell_done($urandom_range(0, 2));
        end
        Start = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
